// File: rtl/can_frame_decoder_pkg.sv
// rtl/can_frame_decoder_pkg.sv - shared types, field widths and CRC-15 step for the CAN frame decoder
package can_pkg;

    localparam int ID_W      = 11;
    localparam int DLC_W     = 4;
    localparam int CRC_W     = 15;
    localparam int DATA_W    = 64;
    localparam int PAYLOAD_W = 1 + ID_W + DATA_W;

    localparam logic [CRC_W-1:0] CRC15_POLY = 15'h4599;

    typedef logic [PAYLOAD_W-1:0] payload_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ID,
        S_CTRL,
        S_DATA,
        S_CRC,
        S_CRC_DEL,
        S_ACK,
        S_ACK_DEL,
        S_EOF,
        S_ERR_WAIT
    } state_t;

    function automatic logic [CRC_W-1:0] crc15_step(input logic [CRC_W-1:0] crc, input logic din);
        return {crc[CRC_W-2:0], 1'b0} ^ ((crc[CRC_W-1] ^ din) ? CRC15_POLY : '0);
    endfunction

endpackage

// File: rtl/can_frame_decoder_if.sv
// rtl/can_frame_decoder_if.sv - serial input and decoded-frame output bundle of the CAN frame decoder
interface can_frame_decoder_if;
    import can_pkg::*;

    logic             rxbit;
    logic             bit_en;
    payload_t         payload_out;
    logic [DLC_W-1:0] dlc_out;
    logic             rtr_out;
    logic             frame_valid;
    logic             crc_err;
    logic             stuff_err;
    logic             form_err;
    logic             busy;

    modport master (
        output rxbit, bit_en,
        input  payload_out, dlc_out, rtr_out, frame_valid, crc_err, stuff_err, form_err, busy
    );

    modport slave (
        input  rxbit, bit_en,
        output payload_out, dlc_out, rtr_out, frame_valid, crc_err, stuff_err, form_err, busy
    );

endinterface

// File: rtl/can_crc15.sv
// rtl/can_crc15.sv - serial CRC-15 register with synchronous clear and bit enable
module can_crc15
    import can_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [CRC_W-1:0] crc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= '0;
        end else if (clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= crc15_step(crc, din);
        end
    end

endmodule

// File: rtl/can_frame_decoder.sv
// rtl/can_frame_decoder.sv - CAN 2.0A base frame receiver: destuffing, field capture, CRC and form checks
module can_frame_decoder
    import can_pkg::*;
#(
    parameter int EOF_LEN  = 7,
    parameter int IDLE_LEN = 11
) (
    input logic                clk,
    input logic                rst,
    can_frame_decoder_if.slave bus
);

    localparam int ERR_CNT_W = $clog2(IDLE_LEN + 1);
    localparam logic [6:0]           EOF_LAST = 7'(EOF_LEN - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_LAST = ERR_CNT_W'(IDLE_LEN - 1);

    state_t                state, state_d;
    logic [6:0]            bit_cnt;
    logic [2:0]            run_cnt;
    logic                  last_bit;
    logic [ID_W-1:0]       id_r;
    logic                  rtr_r;
    logic [DLC_W-1:0]      dlc_r;
    logic [DATA_W-1:0]     data_r;
    logic [CRC_W-2:0]      crc_rx;
    logic                  crc_ok;
    logic [CRC_W-1:0]      crc_calc;
    logic [ERR_CNT_W-1:0]  err_cnt;

    payload_t              payload_q;
    logic [DLC_W-1:0]      dlc_q;
    logic                  rtr_q;
    logic                  valid_q, crc_err_q, stuff_err_q, form_err_q;

    logic                  stuff_region, stuff_slot, crc_en;
    logic                  valid_d, crc_err_d, stuff_err_d, form_err_d;
    logic [DLC_W-1:0]      dlc_new, dlc_eff;
    logic [6:0]            data_last;
    logic [5:0]            data_idx;

    can_crc15 u_crc (
        .clk (clk),
        .rst (rst),
        .clr (state == S_IDLE),
        .en  (crc_en),
        .din (bus.rxbit),
        .crc (crc_calc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d      = state;
        valid_d      = 1'b0;
        crc_err_d    = 1'b0;
        stuff_err_d  = 1'b0;
        form_err_d   = 1'b0;
        crc_en       = 1'b0;
        // CRC_DEL stays in the region so a stuff bit after the last CRC bit is still removed
        stuff_region = state inside {S_ID, S_CTRL, S_DATA, S_CRC, S_CRC_DEL};
        stuff_slot   = stuff_region && (run_cnt == 3'd5);
        dlc_new      = {dlc_r[DLC_W-2:0], bus.rxbit};
        dlc_eff      = (dlc_r > 4'd8) ? 4'd8 : dlc_r;
        data_last    = {dlc_eff, 3'b000} - 7'd1;
        data_idx     = 6'd63 - bit_cnt[5:0];
        if (bus.bit_en) begin
            if (stuff_slot) begin
                if (bus.rxbit == last_bit) begin
                    stuff_err_d = 1'b1;
                    state_d     = S_ERR_WAIT;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (!bus.rxbit) state_d = S_ID;
                    end
                    S_ID: begin
                        crc_en = 1'b1;
                        if (bit_cnt == 7'd11) state_d = S_CTRL;
                    end
                    S_CTRL: begin
                        crc_en = 1'b1;
                        if (bit_cnt == 7'd0 && bus.rxbit) begin
                            form_err_d = 1'b1;
                            state_d    = S_ERR_WAIT;
                        end else if (bit_cnt == 7'd5) begin
                            state_d = (rtr_r || dlc_new == 4'd0) ? S_CRC : S_DATA;
                        end
                    end
                    S_DATA: begin
                        crc_en = 1'b1;
                        if (bit_cnt == data_last) state_d = S_CRC;
                    end
                    S_CRC: begin
                        if (bit_cnt == 7'd14) state_d = S_CRC_DEL;
                    end
                    S_CRC_DEL: begin
                        if (!bus.rxbit) begin
                            form_err_d = 1'b1;
                            state_d    = S_ERR_WAIT;
                        end else if (!crc_ok) begin
                            crc_err_d = 1'b1;
                            state_d   = S_ERR_WAIT;
                        end else begin
                            state_d = S_ACK;
                        end
                    end
                    S_ACK: begin
                        state_d = S_ACK_DEL;
                    end
                    S_ACK_DEL: begin
                        if (!bus.rxbit) begin
                            form_err_d = 1'b1;
                            state_d    = S_ERR_WAIT;
                        end else begin
                            state_d = S_EOF;
                        end
                    end
                    S_EOF: begin
                        if (!bus.rxbit) begin
                            form_err_d = 1'b1;
                            state_d    = S_ERR_WAIT;
                        end else if (bit_cnt == EOF_LAST) begin
                            valid_d = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                    S_ERR_WAIT: begin
                        if (bus.rxbit && err_cnt == ERR_LAST) state_d = S_IDLE;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt     <= '0;
            run_cnt     <= '0;
            last_bit    <= 1'b0;
            id_r        <= '0;
            rtr_r       <= 1'b0;
            dlc_r       <= '0;
            data_r      <= '0;
            crc_rx      <= '0;
            crc_ok      <= 1'b0;
            err_cnt     <= '0;
            payload_q   <= '0;
            dlc_q       <= '0;
            rtr_q       <= 1'b0;
            valid_q     <= 1'b0;
            crc_err_q   <= 1'b0;
            stuff_err_q <= 1'b0;
            form_err_q  <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            crc_err_q   <= crc_err_d;
            stuff_err_q <= stuff_err_d;
            form_err_q  <= form_err_d;
            if (bus.bit_en) begin
                if (stuff_slot) begin
                    run_cnt  <= 3'd1;
                    last_bit <= bus.rxbit;
                end else begin
                    if (stuff_region && state != S_CRC_DEL) begin
                        run_cnt  <= (bus.rxbit == last_bit) ? run_cnt + 3'd1 : 3'd1;
                        last_bit <= bus.rxbit;
                    end
                    case (state)
                        S_IDLE: begin
                            if (!bus.rxbit) begin
                                run_cnt  <= 3'd1;
                                last_bit <= 1'b0;
                                bit_cnt  <= '0;
                                id_r     <= '0;
                                rtr_r    <= 1'b0;
                                dlc_r    <= '0;
                                data_r   <= '0;
                                crc_rx   <= '0;
                            end
                        end
                        S_ID: begin
                            if (bit_cnt == 7'd11) begin
                                rtr_r   <= bus.rxbit;
                                bit_cnt <= '0;
                            end else begin
                                id_r    <= {id_r[ID_W-2:0], bus.rxbit};
                                bit_cnt <= bit_cnt + 7'd1;
                            end
                        end
                        S_CTRL: begin
                            if (bit_cnt >= 7'd2) dlc_r <= dlc_new;
                            bit_cnt <= (bit_cnt == 7'd5) ? 7'd0 : bit_cnt + 7'd1;
                        end
                        S_DATA: begin
                            data_r[data_idx] <= bus.rxbit;
                            bit_cnt <= (bit_cnt == data_last) ? 7'd0 : bit_cnt + 7'd1;
                        end
                        S_CRC: begin
                            crc_rx <= {crc_rx[CRC_W-3:0], bus.rxbit};
                            if (bit_cnt == 7'd14) begin
                                bit_cnt <= '0;
                                crc_ok  <= ({crc_rx, bus.rxbit} == crc_calc);
                            end else begin
                                bit_cnt <= bit_cnt + 7'd1;
                            end
                        end
                        S_EOF: begin
                            bit_cnt <= bit_cnt + 7'd1;
                        end
                        S_ERR_WAIT: begin
                            if (!bus.rxbit || err_cnt == ERR_LAST) begin
                                err_cnt <= '0;
                            end else begin
                                err_cnt <= err_cnt + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            if (valid_d) begin
                payload_q <= {1'b0, id_r, data_r};
                dlc_q     <= dlc_r;
                rtr_q     <= rtr_r;
            end
        end
    end

    assign bus.payload_out = payload_q;
    assign bus.dlc_out     = dlc_q;
    assign bus.rtr_out     = rtr_q;
    assign bus.frame_valid = valid_q;
    assign bus.crc_err     = crc_err_q;
    assign bus.stuff_err   = stuff_err_q;
    assign bus.form_err    = form_err_q;
    assign bus.busy        = (state != S_IDLE);

endmodule

// File: tb/tb_can_frame_decoder.sv
// tb/tb_can_frame_decoder.sv - randomized frame stimulus checked against a bit-list frame model
module tb_can_frame_decoder;
    import can_pkg::*;

    localparam int EOF_LEN  = 7;
    localparam int IDLE_LEN = 11;
    localparam int K_VALID = 0, K_CRC = 1, K_STUFF = 2, K_FORM = 3;
    localparam int E_NONE = 0, E_CRC = 1, E_STUFF = 2, E_CRCDEL = 3, E_ACKDEL = 4, E_EOF = 5, E_IDE = 6;

    typedef struct {
        int          at;
        int          kind;
        logic [75:0] payload;
        logic [3:0]  dlc;
        logic        rtr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    can_frame_decoder_if bus ();
    can_frame_decoder #(.EOF_LEN(EOF_LEN), .IDLE_LEN(IDLE_LEN)) dut (.clk(clk), .rst(rst), .bus(bus));

    int          checks = 0;
    int          errors = 0;
    int          ncyc   = 0;
    int          mode   = 0;
    exp_t        eq[$];
    logic [75:0] m_payload = '0;
    logic [3:0]  m_dlc = '0;
    logic        m_rtr = 1'b0;

    bit          wq[$];
    int          lmap[$];
    int          stuff_pos[$];
    int          ev_idx, ev_kind;
    logic [75:0] e_payload;
    logic [3:0]  e_dlc;
    logic        e_rtr;

    task automatic check(input string name, input logic [75:0] act, input logic [75:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    function automatic logic [3:0] onehot(input int k);
        logic [3:0] w;
        w = 4'b1000;
        return w >> k;
    endfunction

    // Logical frame -> CRC -> stuffed wire bits, plus where the decoder must react
    task automatic build(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                         input logic [63:0] data, input int err);
        bit          lq[$];
        logic [14:0] crc;
        logic        crc_nxt;
        logic [63:0] dm;
        int          nb, run, k, crcdel_i, ackdel_i, eof_bad_i;
        bit          last;
        lq = {}; wq = {}; lmap = {}; stuff_pos = {};
        lq.push_back(1'b0);
        for (int i = 10; i >= 0; i--) lq.push_back(id[i]);
        lq.push_back(rtr);
        lq.push_back(err == E_IDE);
        lq.push_back(1'b0);
        for (int i = 3; i >= 0; i--) lq.push_back(dlc[i]);
        nb = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
        dm = '0;
        for (int i = 0; i < nb * 8; i++) begin
            lq.push_back(data[63-i]);
            dm[63-i] = data[63-i];
        end
        crc = '0;
        foreach (lq[i]) begin
            crc_nxt = lq[i] ^ crc[14];
            crc = crc << 1;
            if (crc_nxt) crc = crc ^ 15'h4599;
        end
        if (err == E_CRC) begin
            k = $urandom_range(14, 0);
            crc[k] = ~crc[k];
        end
        for (int i = 14; i >= 0; i--) lq.push_back(crc[i]);
        run = 0; last = 1'b0;
        foreach (lq[i]) begin
            lmap.push_back(wq.size());
            wq.push_back(lq[i]);
            if (i > 0 && lq[i] == last) run++; else run = 1;
            last = lq[i];
            if (run == 5) begin
                stuff_pos.push_back(wq.size());
                wq.push_back(!last);
                last = !last;
                run = 1;
            end
        end
        crcdel_i = wq.size();
        wq.push_back(err != E_CRCDEL);
        wq.push_back(1'($urandom_range(1, 0)));
        ackdel_i = wq.size();
        wq.push_back(err != E_ACKDEL);
        k = $urandom_range(EOF_LEN - 1, 0);
        eof_bad_i = wq.size() + k;
        for (int i = 0; i < EOF_LEN; i++) wq.push_back(!(err == E_EOF && i == k));
        ev_kind = K_VALID;
        ev_idx  = wq.size() - 1;
        case (err)
            E_CRC:    begin ev_kind = K_CRC;  ev_idx = crcdel_i; end
            E_CRCDEL: begin ev_kind = K_FORM; ev_idx = crcdel_i; end
            E_ACKDEL: begin ev_kind = K_FORM; ev_idx = ackdel_i; end
            E_EOF:    begin ev_kind = K_FORM; ev_idx = eof_bad_i; end
            E_IDE:    begin ev_kind = K_FORM; ev_idx = lmap[13]; end
            E_STUFF: begin
                if (stuff_pos.size() > 0) begin
                    ev_kind = K_STUFF;
                    ev_idx  = stuff_pos[0];
                    wq[ev_idx] = !wq[ev_idx];
                end
            end
            default: ;
        endcase
        e_payload = {1'b0, id, dm};
        e_dlc     = dlc;
        e_rtr     = rtr;
    endtask

    task automatic send_bit(input bit b, input bit is_ev);
        int   gaps;
        exp_t e;
        gaps = (mode == 0) ? 0 : (mode == 1) ? 2 : $urandom_range(2, 0);
        for (int g = 0; g < gaps; g++) begin
            bus.bit_en = 1'b0;
            bus.rxbit  = 1'($urandom_range(1, 0));
            @(posedge clk); #1;
        end
        if (is_ev) begin
            e.at = ncyc + 2; e.kind = ev_kind;
            e.payload = e_payload; e.dlc = e_dlc; e.rtr = e_rtr;
            eq.push_back(e);
        end
        bus.bit_en = 1'b1;
        bus.rxbit  = b;
        @(posedge clk); #1;
        bus.bit_en = 1'b0;
    endtask

    task automatic send_frame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                              input logic [63:0] data, input int err, input bit tail);
        build(id, rtr, dlc, data, err);
        for (int i = 0; i <= ev_idx; i++) send_bit(wq[i], i == ev_idx);
        if (tail) begin
            repeat ((ev_kind == K_VALID) ? 3 : IDLE_LEN + 2) send_bit(1'b1, 1'b0);
            check("busy_after_frame", bus.busy, 0);
        end
    endtask

    always @(negedge clk) begin
        exp_t       e;
        logic [3:0] got;
        ncyc++;
        got = {bus.frame_valid, bus.crc_err, bus.stuff_err, bus.form_err};
        if (eq.size() > 0 && eq[0].at == ncyc) begin
            e = eq.pop_front();
            if (e.kind == K_VALID) begin
                m_payload = e.payload; m_dlc = e.dlc; m_rtr = e.rtr;
            end
            check("pulse", got, onehot(e.kind));
            check("busy_at_event", bus.busy, e.kind != K_VALID);
        end else begin
            check("no_pulse", got, 0);
        end
        check("payload", bus.payload_out, m_payload);
        check("dlc", bus.dlc_out, m_dlc);
        check("rtr", bus.rtr_out, m_rtr);
    end

    initial begin
        logic [63:0] d;
        rst = 1'b1; bus.rxbit = 1'b1; bus.bit_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_payload", bus.payload_out, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_pulses", {bus.frame_valid, bus.crc_err, bus.stuff_err, bus.form_err}, 0);
        rst = 1'b0;
        repeat (2) send_bit(1'b1, 1'b0);

        send_frame(11'h000, 1'b0, 4'd8, 64'h0, E_NONE, 1'b1);
        check("lit_zero_dlc", bus.dlc_out, 4'd8);
        send_frame(11'h000, 1'b0, 4'd8, 64'h0, E_STUFF, 1'b1);

        send_frame(11'h123, 1'b0, 4'd8, 64'h1122334455667788, E_NONE, 1'b1);
        check("lit_034_payload", bus.payload_out, 76'h123_1122334455667788);
        check("lit_034_dlc", bus.dlc_out, 4'd8);

        send_frame(11'h7FF, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, E_CRC, 1'b1);
        check("lit_036_payload_held", bus.payload_out, 76'h123_1122334455667788);

        send_frame(11'h2AB, 1'b0, 4'd1, 64'h3C00_0000_0000_0000, E_ACKDEL, 1'b0);
        repeat (4) send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        repeat (IDLE_LEN - 1) send_bit(1'b1, 1'b0);
        check("errwait_hold", bus.busy, 1);
        send_bit(1'b1, 1'b0);
        check("errwait_exit", bus.busy, 0);

        send_frame(11'h456, 1'b1, 4'd4, {$urandom, $urandom}, E_NONE, 1'b1);
        check("lit_rtr_payload", bus.payload_out, 76'h456_0000000000000000);
        check("lit_rtr_flag", bus.rtr_out, 1);
        send_frame(11'h0F0, 1'b0, 4'd3, {$urandom, $urandom}, E_NONE, 1'b1);
        mode = 1;
        send_frame(11'h456, 1'b1, 4'd4, {$urandom, $urandom}, E_NONE, 1'b1);
        check("lit_rtr_slow_payload", bus.payload_out, 76'h456_0000000000000000);
        check("lit_rtr_slow_dlc", bus.dlc_out, 4'd4);
        check("lit_rtr_slow_flag", bus.rtr_out, 1);

        for (int n = 0; n < 60; n++) begin
            int err;
            mode = $urandom_range(2, 0);
            err  = $urandom_range(9, 0);
            if (err > E_IDE) err = E_NONE;
            send_frame(11'($urandom), ($urandom_range(3, 0) == 0), 4'($urandom_range(15, 0)),
                       {$urandom, $urandom}, err, 1'b1);
        end

        mode = 0;
        send_frame(11'h123, 1'b0, 4'd8, 64'h1122334455667788, E_NONE, 1'b1);
        d = {$urandom, $urandom};
        build(11'h5A5, 1'b0, 4'd8, d, E_NONE);
        for (int i = 0; i <= lmap[29]; i++) send_bit(wq[i], 1'b0);
        rst = 1'b1;
        m_payload = '0; m_dlc = '0; m_rtr = 1'b0;
        #1;
        check("midrst_payload", bus.payload_out, 0);
        check("midrst_dlc", bus.dlc_out, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_pulses", {bus.frame_valid, bus.crc_err, bus.stuff_err, bus.form_err}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) send_bit(1'b1, 1'b0);
        send_frame(11'h2C3, 1'b0, 4'd3, 64'hDEADBEEF_01234567, E_NONE, 1'b1);
        check("lit_after_rst", bus.payload_out, 76'h2C3_DEADBE0000000000);

        check("expect_queue_empty", eq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
